// File: rtl/ascon_output_collector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ascon_output_collector_pkg                                                 |
// | Shared types and constants for the Ascon output collector.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ascon_output_collector_pkg;

    localparam int TAG_W = 128;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_TAG_HI  = 3'd2,
        S_TAG_LO  = 3'd3,
        S_DONE    = 3'd4
    } collector_state_t;

endpackage : ascon_output_collector_pkg
`default_nettype wire

// File: rtl/ascon_output_collector_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ascon_output_collector_if                                                  |
// | Host-side valid/ready beat stream carrying cipher words and tag halves.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ascon_output_collector_if #(
    parameter int DATA_W = 64
);

    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_is_tag_o;
    logic              out_last_o;
    logic              out_ready_i;

    modport master (
        output out_valid_o,
        output out_data_o,
        output out_is_tag_o,
        output out_last_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o,
        input  out_data_o,
        input  out_is_tag_o,
        input  out_last_o,
        output out_ready_i
    );

endinterface : ascon_output_collector_if
`default_nettype wire

// File: rtl/ascon_output_collector_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ascon_output_collector_out_fifo                                            |
// | Synchronous cipher-word FIFO with flush; head read straight from storage.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ascon_output_collector_out_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : ascon_output_collector_out_fifo
`default_nettype wire

// File: rtl/ascon_output_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ascon_output_collector                                                     |
// | Buffers Ascon cipher words and tag, replays them as a 64-bit beat stream.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ascon_output_collector
    import ascon_output_collector_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int NB_BLOCKS  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clock_i,
    input  logic                     resetb_i,
    input  logic                     start_i,
    input  logic                     cipher_valid_i,
    input  logic [DATA_W-1:0]        cipher_i,
    input  logic                     end_i,
    input  logic [TAG_W-1:0]         tag_i,
    ascon_output_collector_if.master out_bus,
    output logic                     done_o,
    output logic                     err_o
);

    localparam int CNT_W = $clog2(NB_BLOCKS + 1);
    localparam logic [CNT_W-1:0] NB_CNT = CNT_W'(NB_BLOCKS);

    collector_state_t  state_q;
    collector_state_t  state_d;
    logic              start_q;
    logic              end_q;
    logic [TAG_W-1:0]  tag_q;
    logic              tag_ok_q;
    logic [CNT_W-1:0]  sent_cnt_q;
    logic [CNT_W-1:0]  cap_cnt_q;
    logic              err_q;

    logic              start_rise;
    logic              tag_edge;
    logic              in_collect;
    logic              push_req;
    logic              overflow;
    logic              push_acc;
    logic              stray;
    logic              premature;
    logic              cipher_done;
    logic [CNT_W:0]    cap_after;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;

    logic              beat_valid;
    logic [DATA_W-1:0] beat_data;
    logic              beat_is_tag;
    logic              beat_last;
    logic              done_flag;

    assign start_rise  = start_i & ~start_q;
    assign tag_edge    = end_i & ~end_q;
    assign in_collect  = (state_q == S_COLLECT);
    // A restart edge discards whatever strobe arrives alongside it.
    assign push_req    = cipher_valid_i & in_collect & ~start_rise;
    assign overflow    = push_req & fifo_full & ~fifo_pop;
    assign push_acc    = push_req & ~overflow;
    assign stray       = cipher_valid_i & ~in_collect & ~start_rise;
    assign cipher_done = (sent_cnt_q == NB_CNT) & tag_ok_q;
    // A word captured in the same cycle as the tag edge still counts toward the message.
    assign cap_after   = {1'b0, cap_cnt_q} + {{CNT_W{1'b0}}, push_acc};
    assign premature   = tag_edge & in_collect & (cap_after < {1'b0, NB_CNT});

    ascon_output_collector_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clock_i),
        .rst_n     (resetb_i),
        .flush     (start_rise),
        .push      (push_acc),
        .push_data (cipher_i),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_valid  = 1'b0;
        beat_data   = '0;
        beat_is_tag = 1'b0;
        beat_last   = 1'b0;
        done_flag   = 1'b0;
        fifo_pop    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_rise) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                beat_valid = ~fifo_empty & ~cipher_done;
                beat_data  = beat_valid ? fifo_head : '0;
                fifo_pop   = beat_valid & out_bus.out_ready_i;
                if (!start_rise && cipher_done) state_d = S_TAG_HI;
            end
            S_TAG_HI: begin
                beat_valid  = 1'b1;
                beat_data   = tag_q[TAG_W-1 -: DATA_W];
                beat_is_tag = 1'b1;
                if (start_rise)               state_d = S_COLLECT;
                else if (out_bus.out_ready_i) state_d = S_TAG_LO;
            end
            S_TAG_LO: begin
                beat_valid  = 1'b1;
                beat_data   = tag_q[DATA_W-1:0];
                beat_is_tag = 1'b1;
                beat_last   = 1'b1;
                if (start_rise)               state_d = S_COLLECT;
                else if (out_bus.out_ready_i) state_d = S_DONE;
            end
            S_DONE: begin
                done_flag = 1'b1;
                if (start_rise) state_d = S_COLLECT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            start_q    <= 1'b0;
            end_q      <= 1'b0;
            tag_q      <= '0;
            tag_ok_q   <= 1'b0;
            sent_cnt_q <= '0;
            cap_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            start_q <= start_i;
            end_q   <= end_i;
            if (start_rise) begin
                tag_ok_q   <= 1'b0;
                sent_cnt_q <= '0;
                cap_cnt_q  <= '0;
                err_q      <= 1'b0;
            end else begin
                if (fifo_pop && sent_cnt_q != NB_CNT) begin
                    sent_cnt_q <= sent_cnt_q + CNT_W'(1);
                end
                if (push_acc && cap_cnt_q != NB_CNT) begin
                    cap_cnt_q <= cap_cnt_q + CNT_W'(1);
                end
                // Only the first cycle of the end level carries a fresh tag.
                if (tag_edge && in_collect) begin
                    tag_q    <= tag_i;
                    tag_ok_q <= 1'b1;
                end
                if (overflow || stray || premature) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign out_bus.out_valid_o  = beat_valid;
    assign out_bus.out_data_o   = beat_data;
    assign out_bus.out_is_tag_o = beat_is_tag;
    assign out_bus.out_last_o   = beat_last;
    assign done_o               = done_flag;
    assign err_o                = err_q;

endmodule : ascon_output_collector
`default_nettype wire
